// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store controller: data widths,
// RV32I load/store size codes, controller states and request-decode helpers.
package lsu_mem_ctrl_pkg;

  localparam int unsigned CPU_WIDTH           = 32;
  localparam int unsigned DATA_MEM_ADDR_WIDHT = 12;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;

  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_RD,
    LSU_LD_RSP,
    LSU_ST_MRG,
    LSU_ST_WR,
    LSU_ERR
  } lsu_state_e;

  // Stores only know b/h/w; loads additionally know bu/hu.
  function automatic logic lsu_f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) bad = f3[2] || (f3[1:0] == 2'b11);
    else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return bad;
  endfunction

  // Halfwords need even addresses, words need word-aligned addresses.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Lane steering for the load/store controller: extracts and extends load
// data from the memory word, and merges sub-word store data into it.
module lsu_align #(
  parameter int unsigned CPU_WIDTH = lsu_mem_ctrl_pkg::CPU_WIDTH
) (
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [CPU_WIDTH-1:0] rdata_i,
  input  logic [CPU_WIDTH-1:0] wdata_i,
  output logic [CPU_WIDTH-1:0] ld_data_o,
  output logic [CPU_WIDTH-1:0] st_data_o
);
  import lsu_mem_ctrl_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the addressed byte/half lane and sign- or zero-extend it.
  always_comb begin
    byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      LSU_LB:  ld_data_o = {{(CPU_WIDTH-8){byte_v[7]}}, byte_v};
      LSU_LH:  ld_data_o = {{(CPU_WIDTH-16){half_v[15]}}, half_v};
      LSU_LW:  ld_data_o = rdata_i;
      LSU_LBU: ld_data_o = {{(CPU_WIDTH-8){1'b0}}, byte_v};
      LSU_LHU: ld_data_o = {{(CPU_WIDTH-16){1'b0}}, half_v};
      default: ld_data_o = '0;
    endcase
  end

  // Overlay the store lane onto the word read back from memory.
  always_comb begin
    st_data_o = rdata_i;
    case (funct3_i)
      LSU_SB:  st_data_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      LSU_SH:  st_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: st_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and the word-wide data memory.
// One request per handshake; sub-word stores are done as read-modify-write.
module lsu_mem_ctrl #(
  parameter int unsigned CPU_WIDTH = lsu_mem_ctrl_pkg::CPU_WIDTH,
  parameter int unsigned MEM_AW    = lsu_mem_ctrl_pkg::DATA_MEM_ADDR_WIDHT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [2:0]           req_funct3_i,
  input  logic [CPU_WIDTH-1:0] req_addr_i,
  input  logic [CPU_WIDTH-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  output logic                 resp_err_o,
  output logic [CPU_WIDTH-1:0] resp_rdata_o,
  output logic [CPU_WIDTH-1:0] mem_addr_o,
  output logic                 mem_wr_en_o,
  output logic [CPU_WIDTH-1:0] mem_wdata_o,
  input  logic [CPU_WIDTH-1:0] mem_rdata_i
);
  import lsu_mem_ctrl_pkg::*;

  lsu_state_e           state_q, state_d;
  logic                 we_q, we_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [CPU_WIDTH-1:0] addr_q, addr_d;
  logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
  logic [CPU_WIDTH-1:0] ld_data;
  logic [CPU_WIDTH-1:0] st_data;

  lsu_align #(.CPU_WIDTH(CPU_WIDTH)) u_align (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (mem_rdata_i),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_data_o (st_data)
  );

  // Bits above MEM_AW are not decoded by the memory but are passed through.
  assign mem_addr_o = {addr_q[CPU_WIDTH-1:MEM_AW], addr_q[MEM_AW-1:2], 2'b00};

  // State and request registers; reset drops the write strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LSU_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state, request capture and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    resp_rdata_o = '0;
    mem_wr_en_o  = 1'b0;
    mem_wdata_o  = '0;
    case (state_q)
      LSU_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          if (lsu_f3_illegal(req_we_i, req_funct3_i) ||
              lsu_misaligned(req_funct3_i, req_addr_i[1:0]))
            state_d = LSU_ERR;
          else if (req_we_i && (req_funct3_i == LSU_SW))
            state_d = LSU_ST_WR;
          else
            state_d = LSU_RD;
        end
      end
      LSU_RD: begin
        state_d = we_q ? LSU_ST_MRG : LSU_LD_RSP;
      end
      LSU_LD_RSP: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = ld_data;
        state_d      = LSU_IDLE;
      end
      LSU_ST_MRG: begin
        mem_wr_en_o  = 1'b1;
        mem_wdata_o  = st_data;
        resp_valid_o = 1'b1;
        state_d      = LSU_IDLE;
      end
      LSU_ST_WR: begin
        mem_wr_en_o  = 1'b1;
        mem_wdata_o  = wdata_q;
        resp_valid_o = 1'b1;
        state_d      = LSU_IDLE;
      end
      LSU_ERR: begin
        resp_valid_o = 1'b1;
        resp_err_o   = 1'b1;
        state_d      = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a registered-read word memory model.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_err_o;
  logic [31:0] resp_rdata_o;
  logic [31:0] mem_addr_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned n_fail;

  lsu_mem_ctrl #(.CPU_WIDTH(32), .MEM_AW(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_err_o   (resp_err_o),
    .resp_rdata_o (resp_rdata_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wr_en_o  (mem_wr_en_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: write on strobe, registered read; backdoor port for preload.
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_wr_en_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;
    mem_rdata_i <= mem[mem_addr_o[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [7:0] idx, input logic [31:0] data);
    bd_we   = 1'b1;
    bd_idx  = idx;
    bd_data = data;
    @(posedge clk); #1;
    bd_we   = 1'b0;
  endtask

  // Issue one request from IDLE and measure response latency, error, data
  // and the cycle of the write strobe (0 when no write occurs).
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_lat, input logic exp_err,
                         input logic [31:0] exp_rd, input int exp_wr);
    int          lat;
    int          wr_cyc;
    logic        err;
    logic [31:0] rd;
    lat    = 0;
    wr_cyc = 0;
    err    = 1'b0;
    rd     = '0;
    chk({tag, " ready"}, {31'd0, req_ready_o}, 32'd1);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    @(posedge clk); #1;
    req_valid_i  = 1'b0;
    for (int c = 1; c <= 4 && lat == 0; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (mem_wr_en_o && wr_cyc == 0) wr_cyc = c;
      if (resp_valid_o) begin
        lat = c;
        err = resp_err_o;
        rd  = resp_rdata_o;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " wr cycle"}, wr_cyc, exp_wr);
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b000;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    bd_we        = 1'b0;
    bd_idx       = '0;
    bd_data      = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset ready",    {31'd0, req_ready_o},  32'd1);
    chk("reset rvalid",   {31'd0, resp_valid_o}, 32'd0);
    chk("reset rerr",     {31'd0, resp_err_o},   32'd0);
    chk("reset rdata",    resp_rdata_o,          32'd0);
    chk("reset mem_addr", mem_addr_o,            32'd0);
    chk("reset wr_en",    {31'd0, mem_wr_en_o},  32'd0);
    chk("reset wdata",    mem_wdata_o,           32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word store then load back.
    run_req("sw 10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 1'b0, 32'h0, 1);
    chk("mem 10 after sw", mem[4], 32'hDEADBEEF);
    run_req("lw 10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);

    // Sub-word stores merge into the existing word.
    bd_write(8'd8, 32'h11223344);
    run_req("sb 21", 1'b1, 3'b000, 32'h21, 32'h000000AA, 2, 1'b0, 32'h0, 2);
    chk("mem 20 after sb", mem[8], 32'h1122AA44);
    run_req("lw 20", 1'b0, 3'b010, 32'h20, 32'h0, 2, 1'b0, 32'h1122AA44, 0);
    run_req("sh 22", 1'b1, 3'b001, 32'h22, 32'h1234BEEF, 2, 1'b0, 32'h0, 2);
    chk("mem 20 after sh", mem[8], 32'hBEEFAA44);

    // Lane extraction and extension.
    bd_write(8'd12, 32'h80FF7F01);
    run_req("lb 32",  1'b0, 3'b000, 32'h32, 32'h0, 2, 1'b0, 32'hFFFFFFFF, 0);
    run_req("lbu 32", 1'b0, 3'b100, 32'h32, 32'h0, 2, 1'b0, 32'h000000FF, 0);
    run_req("lh 32",  1'b0, 3'b001, 32'h32, 32'h0, 2, 1'b0, 32'hFFFF80FF, 0);
    run_req("lhu 30", 1'b0, 3'b101, 32'h30, 32'h0, 2, 1'b0, 32'h00007F01, 0);
    run_req("lb 30",  1'b0, 3'b000, 32'h30, 32'h0, 2, 1'b0, 32'h00000001, 0);
    run_req("lb 31",  1'b0, 3'b000, 32'h31, 32'h0, 2, 1'b0, 32'h0000007F, 0);
    run_req("lbu 33", 1'b0, 3'b100, 32'h33, 32'h0, 2, 1'b0, 32'h00000080, 0);
    run_req("lh 30",  1'b0, 3'b001, 32'h30, 32'h0, 2, 1'b0, 32'h00007F01, 0);
    run_req("lw 30",  1'b0, 3'b010, 32'h30, 32'h0, 2, 1'b0, 32'h80FF7F01, 0);

    // Misaligned and illegal requests.
    run_req("err lh 41",    1'b0, 3'b001, 32'h41, 32'h0,      1, 1'b1, 32'h0, 0);
    run_req("err sw 42",    1'b1, 3'b010, 32'h42, 32'hFFFF,   1, 1'b1, 32'h0, 0);
    run_req("err ld f3 3",  1'b0, 3'b011, 32'h40, 32'h0,      1, 1'b1, 32'h0, 0);
    run_req("err st f3 4",  1'b1, 3'b100, 32'h40, 32'h12345678, 1, 1'b1, 32'h0, 0);

    // Reset while the sub-word write strobe is up.
    bd_write(8'd20, 32'h55667788);
    chk("rst ready", {31'd0, req_ready_o}, 32'd1);
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_funct3_i = 3'b000;
    req_addr_i   = 32'h52;
    req_wdata_i  = 32'h000000CC;
    @(posedge clk); #1;
    req_valid_i  = 1'b0;
    chk("rst rd wr_en", {31'd0, mem_wr_en_o}, 32'd0);
    @(posedge clk); #1;
    chk("rst mrg wr_en", {31'd0, mem_wr_en_o}, 32'd1);
    chk("rst mrg wdata", mem_wdata_o, 32'h55CC7788);
    #1 rst_n = 1'b0;
    #1;
    chk("rst wr_en drop", {31'd0, mem_wr_en_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst mem untouched", mem[20], 32'h55667788);
    chk("rst ready after", {31'd0, req_ready_o}, 32'd1);
    chk("rst no resp", {31'd0, resp_valid_o}, 32'd0);

    // Back-to-back loads with valid held high.
    bd_write(8'd0, 32'h01020304);
    bd_write(8'd1, 32'h0A0B0C0D);
    chk("b2b ready0", {31'd0, req_ready_o}, 32'd1);
    req_valid_i  = 1'b1;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b010;
    req_addr_i   = 32'h0;
    @(posedge clk); #1;
    req_addr_i   = 32'h4;
    chk("b2b c1 ready", {31'd0, req_ready_o}, 32'd0);
    @(posedge clk); #1;
    chk("b2b c2 ready", {31'd0, req_ready_o}, 32'd0);
    chk("b2b c2 rvalid", {31'd0, resp_valid_o}, 32'd1);
    chk("b2b c2 rdata", resp_rdata_o, 32'h01020304);
    @(posedge clk); #1;
    chk("b2b c3 ready", {31'd0, req_ready_o}, 32'd1);
    chk("b2b c3 rvalid", {31'd0, resp_valid_o}, 32'd0);
    @(posedge clk); #1;
    req_valid_i  = 1'b0;
    chk("b2b c4 ready", {31'd0, req_ready_o}, 32'd0);
    @(posedge clk); #1;
    chk("b2b c5 rvalid", {31'd0, resp_valid_o}, 32'd1);
    chk("b2b c5 rdata", resp_rdata_o, 32'h0A0B0C0D);
    @(posedge clk); #1;
    chk("b2b idle ready", {31'd0, req_ready_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller between the MEM pipeline stage and the word-wide data memory. Accepts one load or store per handshake, performs byte/halfword extraction with sign/zero extension for loads and read-modify-write merging for sub-word stores, and flags misaligned or illegal accesses. It drives the data memory's word address, write enable and write data ports, and consumes its registered one-cycle read data.

## Interface
- `CPU_WIDTH`, default `` `CPU_WIDTH `` (32): data and address width.
- `MEM_AW`, default `` `DATA_MEM_ADDR_WIDHT ``: byte-address bits the memory decodes.
- Reset `rst_n` is asynchronous and active-low; the clock is `clk`.
- `clk`: input, 1 bit, clock.
- `rst_n`: input, 1 bit, asynchronous active-low reset.
- `req_valid_i`: input, 1 bit, request present.
- `req_ready_o`: output, 1 bit, controller idle and able to accept.
- `req_we_i`: input, 1 bit, 1 = store, 0 = load.
- `req_funct3_i`: input, 3 bits, RV32I size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `req_addr_i`: input, CPU_WIDTH bits, byte address.
- `req_wdata_i`: input, CPU_WIDTH bits, store data (low bits used for sb/sh).
- `resp_valid_o`: output, 1 bit, one-cycle completion pulse.
- `resp_err_o`: output, 1 bit, misaligned or illegal access (valid with `resp_valid_o`).
- `resp_rdata_o`: output, CPU_WIDTH bits, formatted load data. Zero for stores and errors.
- `mem_addr_o`: output, CPU_WIDTH bits, byte address to memory. Low two bits are forced to 0.
- `mem_wr_en_o`: output, 1 bit, memory write strobe.
- `mem_wdata_o`: output, CPU_WIDTH bits, full word to write.
- `mem_rdata_i`: input, CPU_WIDTH bits, memory read data, registered. Valid the cycle after the address is presented.

## Operation
- States:
  - IDLE
  - RD: address presented, memory captures read
  - LD_RSP
  - ST_MRG: sub-word write
  - ST_WR: full-word write
  - ERR
- IDLE: `req_ready_o` = 1. On `req_valid_i`, latch we, funct3, addr and wdata into `*_q`.
  - Illegal funct3 goes to ERR. Illegal codes are 011, 110, 111, and any store code with bit 2 set.
  - Misaligned goes to ERR. Halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - sw goes to ST_WR.
  - All other legal requests go to RD.
- RD → LD_RSP for a load, or → ST_MRG for sb/sh.
- LD_RSP: `resp_valid_o` = 1. `resp_rdata_o` is extracted from `mem_rdata_i`:
  - lane = addr_q[1:0] for bytes, addr_q[1] for halves.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
  - Next state is IDLE.
- ST_MRG: `mem_wr_en_o` = 1. `mem_wdata_o` = `mem_rdata_i` with the selected lane replaced by wdata_q[7:0] or wdata_q[15:0]. `resp_valid_o` = 1. Next state is IDLE.
- ST_WR: `mem_wr_en_o` = 1, `mem_wdata_o` = wdata_q, `resp_valid_o` = 1. Next state is IDLE.
- ERR: `resp_valid_o` = 1, `resp_err_o` = 1, no memory access. Next state is IDLE.
- `mem_addr_o` = {addr_q[CPU_WIDTH-1:2], 2'b00} in every state.
- `mem_wdata_o` = 0 outside the write states.
- `mem_wr_en_o` and the `resp_*` outputs are decoded from state only. They never depend on `req_*` in the same cycle.

## Timing
- Reset values: state IDLE; addr_q, wdata_q, funct3_q and we_q = 0; `mem_wr_en_o` 0; `mem_wdata_o` 0; `mem_addr_o` 0; `resp_valid_o` 0; `resp_err_o` 0; `resp_rdata_o` 0; `req_ready_o` 1.
- Latency is counted from the accepting edge to the `resp_valid_o` cycle:
  - load: 2 cycles
  - sb/sh: 2 cycles
  - sw: 1 cycle
  - error: 1 cycle
- Issue interval: load and sub-word store 3 cycles; sw and error 2 cycles.
- `req_ready_o` is low in every state except IDLE. `req_valid_i` outside IDLE is ignored. The requester holds `req_*` stable until accepted.
- Reset asserted mid-operation returns the block to IDLE immediately. `mem_wr_en_o` drops asynchronously and no partial write occurs after reset. Memory contents are not touched by reset.
- Address wrap is not special: the upper bits beyond MEM_AW pass through and the memory ignores them.

## Structure
- Shared defines (`rooth_defines.v`): CPU_WIDTH, DATA_MEM_ADDR_WIDHT, LSU funct3 codes (LSU_LB/LH/LW/LBU/LHU, LSU_SB/SH/SW), LSU state encodings.
- One combinational sub-module `lsu_align` holds the lane extract and sign-extension logic and the store merge logic. It is instantiated once; the FSM and registers stay in `lsu_mem_ctrl`.
- Integration: `lsu_mem_ctrl.mem_*` connects directly to `data_mem` (`adder_i`, `wr_en_i`, `data_i`, `data_o`).

## Test plan
- sw addr 0x10 data 0xDEADBEEF, then lw 0x10 → write strobe one cycle after accept; load returns 0xDEADBEEF with resp_err 0, 2 cycles after accept.
- Memory word at 0x20 = 0x11223344; sb addr 0x21 data 0xAA → RD then ST_MRG writes 0x1122AA44; lw 0x20 reads 0x1122AA44.
- Word at 0x30 = 0x80FF7F01. Loads and expected results:
  - lb 0x32 → 0xFFFFFFFF
  - lbu 0x32 → 0x000000FF
  - lh 0x32 → 0xFFFF80FF
  - lhu 0x30 → 0x00007F01
  - lb 0x30 → 0x00000001
- Error cases each give `resp_err_o` = 1 and `resp_rdata_o` = 0 one cycle after accept, with no `mem_wr_en_o`:
  - lh 0x41
  - sw 0x42
  - funct3 011 load
  - store with funct3 100
- Reset during ST_MRG of a sb → `mem_wr_en_o` falls with `rst_n`, target word is unchanged, and `req_ready_o` is 1 after release.
- `req_valid_i` held high for back-to-back loads 0x0 and 0x4 → second accept occurs exactly 3 cycles after the first, `req_ready_o` is low in between, and responses arrive in order.
